// File: rtl/lsu_stage.sv
// Load/store stage: accepts one execute-stage result at a time, performs at
// most one data-memory access with a WAIT timeout, and presents a single-cycle
// writeback. Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word
// accesses into errors; without it they are aligned down and proceed.
module lsu_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_we,
  output logic        wb_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Last counter value before the access is abandoned.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        load_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic        wb_valid_q, wb_we_q, wb_err_q;
  logic [31:0] wb_data_q;

  // Accept-side decode: access type, effective address, lanes and store data.
  logic        acc_ld, acc_st, acc_mem, acc_err, f3_bad;
  logic [31:0] eff_addr, st_data;
  logic [3:0]  st_be;
  logic [31:0] ld_shift, ld_ext;

  // Decode the incoming op; both load and store set is treated as a load.
  always_comb begin
    acc_ld   = is_load;
    acc_st   = is_store & ~is_load;
    acc_mem  = acc_ld | acc_st;
    f3_bad   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    acc_err  = f3_bad;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((funct3[1:0] == 2'b01 && alu_result[0]) ||
        (funct3[1:0] == 2'b10 && alu_result[1:0] != 2'b00))
      acc_err = 1'b1;
`endif
    eff_addr = alu_result;
    st_be    = 4'b1111;
    st_data  = rs2_data;
    case (funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << eff_addr[1:0];
        st_data = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        eff_addr = {alu_result[31:1], 1'b0};
        st_be    = eff_addr[1] ? 4'b1100 : 4'b0011;
        st_data  = {2{rs2_data[15:0]}};
      end
      default: begin
        eff_addr = {alu_result[31:2], 2'b00};
      end
    endcase
  end

  // Extract the addressed lane from load data and extend it.
  always_comb begin
    ld_shift = mem_rdata >> {mem_addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
      3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Control FSM with registered memory-request and writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      load_q      <= 1'b0;
      funct3_q    <= '0;
      rd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_err_q    <= 1'b0;
      wb_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            rd_q     <= rd_addr;
            cnt_q    <= '0;
            load_q   <= acc_ld;
            funct3_q <= funct3;
            if (!acc_mem) begin
              state_q    <= DONE;
              wb_valid_q <= 1'b1;
              wb_data_q  <= alu_result;
              wb_we_q    <= (rd_addr != 5'd0);
              wb_err_q   <= 1'b0;
            end else if (acc_err) begin
              state_q    <= DONE;
              wb_valid_q <= 1'b1;
              wb_data_q  <= '0;
              wb_we_q    <= 1'b0;
              wb_err_q   <= 1'b1;
            end else begin
              state_q     <= WAIT;
              mem_req_q   <= 1'b1;
              mem_we_q    <= acc_st;
              mem_addr_q  <= eff_addr;
              mem_wdata_q <= st_data;
              mem_be_q    <= st_be;
              wb_data_q   <= '0;
            end
          end
        end
        WAIT: begin
          // Ack beats the timeout when both happen in the same cycle.
          if (mem_ack) begin
            state_q    <= DONE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= '0;
            wb_valid_q <= 1'b1;
            if (load_q) begin
              wb_data_q <= ld_ext;
              wb_we_q   <= (rd_q != 5'd0);
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= DONE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= '0;
            wb_valid_q <= 1'b1;
            wb_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q    <= IDLE;
          wb_valid_q <= 1'b0;
          wb_we_q    <= 1'b0;
          wb_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = rd_q;
  assign wb_data   = wb_data_q;
  assign wb_we     = wb_we_q;
  assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage: stimulus pushes expected writebacks,
// a negedge monitor pops and compares whenever wb_valid is seen.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_addr = '0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_we, wb_err;

  int checks = 0;
  int errors = 0;
  logic [38:0] exp_q[$];
  logic [38:0] mon_e;

  lsu_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .is_load(is_load), .is_store(is_store), .funct3(funct3),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_we(wb_we), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] d, input logic we, input logic err);
    exp_q.push_back({rd, d, we, err});
  endtask

  // Present one op; returns at the negedge following the accepting edge.
  task automatic send(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'b0, in_ready}, 32'd1);
    is_load = ld; is_store = st; funct3 = f3;
    alu_result = a; rs2_data = d; rd_addr = rd;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    $display("op ld=%0b st=%0b f3=%03b addr=0x%08h data=0x%08h rd=%0d", ld, st, f3, a, d, rd);
  endtask

  // Check the request, hold it for dly cycles, then ack with rdata.
  task automatic mem_txn(input logic [31:0] ea, input logic [3:0] eb, input logic ewe,
                         input logic cw, input logic [31:0] ewd, input int dly,
                         input logic [31:0] rdat);
    chk("mem_req", {31'b0, mem_req}, 32'd1);
    chk("mem_addr", mem_addr, ea);
    chk("mem_be", {28'b0, mem_be}, {28'b0, eb});
    chk("mem_we", {31'b0, mem_we}, {31'b0, ewe});
    if (cw) chk("mem_wdata", mem_wdata, ewd);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("mem_req_hold", {31'b0, mem_req}, 32'd1);
      chk("mem_addr_hold", mem_addr, ea);
    end
    mem_ack = 1'b1;
    mem_rdata = rdat;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("mem_req_drop", {31'b0, mem_req}, 32'd0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=0x%08h expected none", wb_rd, wb_data);
      end else begin
        mon_e = exp_q.pop_front();
        $display("wb rd=%0d data=0x%08h we=%0b err=%0b", wb_rd, wb_data, wb_we, wb_err);
        chk("wb_rd", {27'b0, wb_rd}, {27'b0, mon_e[38:34]});
        chk("wb_data", wb_data, mon_e[33:2]);
        chk("wb_we", {31'b0, wb_we}, {31'b0, mon_e[1]});
        chk("wb_err", {31'b0, wb_err}, {31'b0, mon_e[0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_err", {31'b0, wb_err}, 32'd0);
    rst_n = 1'b1;

    // Ack while idle must be ignored
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_ready", {31'b0, in_ready}, 32'd1);
    chk("idle_ack_req", {31'b0, mem_req}, 32'd0);

    // Non-memory ops: one-cycle latency
    expect_wb(5'd5, 32'h0000_1234, 1'b1, 1'b0);
    send(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
    chk("nop_latency", {31'b0, wb_valid}, 32'd1);
    mem_ack = 1'b1;  // ack during DONE also ignored
    expect_wb(5'd0, 32'h0000_1234, 1'b0, 1'b0);
    send(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd0);
    mem_ack = 1'b0;
    chk("nop_rd0_latency", {31'b0, wb_valid}, 32'd1);

    // SB at 0x1003, ack after 3 cycles
    expect_wb(5'd7, 32'h0, 1'b0, 1'b0);
    send(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 5'd7);
    mem_txn(32'h0000_1003, 4'b1000, 1'b1, 1'b1, 32'hDDDD_DDDD, 3, 32'h0);

    // LB / LBU at 0x2001
    expect_wb(5'd3, 32'hFFFF_FFF0, 1'b1, 1'b0);
    send(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0, 5'd3);
    mem_txn(32'h0000_2001, 4'b0010, 1'b0, 1'b0, 32'h0, 0, 32'h0000_F000);
    expect_wb(5'd3, 32'h0000_00F0, 1'b1, 1'b0);
    send(1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0, 5'd3);
    mem_txn(32'h0000_2001, 4'b0010, 1'b0, 1'b0, 32'h0, 1, 32'h0000_F000);

    // SH / LH / LHU at 0x4002
    expect_wb(5'd2, 32'h0, 1'b0, 1'b0);
    send(1'b0, 1'b1, 3'b001, 32'h0000_4002, 32'h1111_BEEF, 5'd2);
    mem_txn(32'h0000_4002, 4'b1100, 1'b1, 1'b1, 32'hBEEF_BEEF, 0, 32'h0);
    expect_wb(5'd11, 32'hFFFF_8001, 1'b1, 1'b0);
    send(1'b1, 1'b0, 3'b001, 32'h0000_4002, 32'h0, 5'd11);
    mem_txn(32'h0000_4002, 4'b1100, 1'b0, 1'b0, 32'h0, 0, 32'h8001_0000);
    expect_wb(5'd11, 32'h0000_8001, 1'b1, 1'b0);
    send(1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'h0, 5'd11);
    mem_txn(32'h0000_4002, 4'b1100, 1'b0, 1'b0, 32'h0, 0, 32'h8001_0000);

    // SW at 0x6000 with immediate ack
    expect_wb(5'd1, 32'h0, 1'b0, 1'b0);
    send(1'b0, 1'b1, 3'b010, 32'h0000_6000, 32'hDEAD_BEEF, 5'd1);
    mem_txn(32'h0000_6000, 4'b1111, 1'b1, 1'b1, 32'hDEAD_BEEF, 0, 32'h0);

    // Load and store both set behaves as a load
    expect_wb(5'd8, 32'h0BAD_F00D, 1'b1, 1'b0);
    send(1'b1, 1'b1, 3'b010, 32'h0000_5000, 32'h0000_0055, 5'd8);
    mem_txn(32'h0000_5000, 4'b1111, 1'b0, 1'b0, 32'h0, 0, 32'h0BAD_F00D);

    // Illegal width codes: no request, error
    expect_wb(5'd10, 32'h0, 1'b0, 1'b1);
    send(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd10);
    chk("bad_f3_ld_noreq", {31'b0, mem_req}, 32'd0);
    expect_wb(5'd12, 32'h0, 1'b0, 1'b1);
    send(1'b0, 1'b1, 3'b111, 32'h0000_0104, 32'h1, 5'd12);
    chk("bad_f3_st_noreq", {31'b0, mem_req}, 32'd0);

    // Timeout: no ack, request held exactly 4 cycles
    expect_wb(5'd4, 32'h0, 1'b0, 1'b1);
    send(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd4);
    c = 0;
    while (mem_req && c < 20) begin
      c++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", c, 32'd4);

    // Ack on the 4th WAIT cycle wins over the timeout
    expect_wb(5'd4, 32'h1234_5678, 1'b1, 1'b0);
    send(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd4);
    mem_txn(32'h0000_3000, 4'b1111, 1'b0, 1'b0, 32'h0, 3, 32'h1234_5678);

    // Misaligned word load at 0x3002
`ifdef LSU_MISALIGN_TRAP_EN
    expect_wb(5'd6, 32'h0, 1'b0, 1'b1);
    send(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 5'd6);
    chk("misalign_noreq", {31'b0, mem_req}, 32'd0);
`else
    expect_wb(5'd6, 32'hCAFE_BABE, 1'b1, 1'b0);
    send(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 5'd6);
    mem_txn(32'h0000_3000, 4'b1111, 1'b0, 1'b0, 32'h0, 0, 32'hCAFE_BABE);
`endif

    // Reset in the second WAIT cycle discards the access
    send(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 5'd9);
    chk("rstw_req_c1", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    chk("rstw_req_c2", {31'b0, mem_req}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_req_async", {31'b0, mem_req}, 32'd0);
    chk("rstw_ready_async", {31'b0, in_ready}, 32'd1);
    chk("rstw_wb_valid", {31'b0, wb_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstw_ready_after", {31'b0, in_ready}, 32'd1);

    // Post-reset sanity op
    expect_wb(5'd31, 32'hA5A5_0000, 1'b1, 1'b0);
    send(1'b0, 1'b0, 3'b010, 32'hA5A5_0000, 32'h0, 5'd31);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
